// File: rtl/stopwatch_counter.sv
// ---------------------------------------------------------------------------
// stopwatch_counter
//
// BCD minutes:seconds time base feeding the seven-segment display stage.
// Counting is advanced by one-cycle enable strobes in the single clk domain.
// Supports pause/resume and an adjust mode that fast-increments either the
// minutes or the seconds field.
//
// Optional build macro:
//   STOPWATCH_SATURATE_EN - when defined, normal counting stops at
//                           MAX_MIN:59 and forces PAUSED instead of wrapping.
//
// Parameters:
//   MAX_MIN      - highest minutes value before wrap (1..99)
//   INIT_RUNNING - state after reset: 1 = RUN, 0 = PAUSED
//
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-high reset (highest priority)
//   tick_1hz - 1 Hz strobe, normal counting
//   tick_2hz - 2 Hz strobe, adjust increments
//   pause    - one-cycle pulse, toggles RUN/PAUSED
//   adj      - level, 1 = adjust mode
//   sel      - level, adjust field: 1 = seconds, 0 = minutes
//   s0, s1   - seconds ones/tens BCD digits
//   m0, m1   - minutes ones/tens BCD digits
//   running  - 1 while in RUN
// ---------------------------------------------------------------------------
module stopwatch_counter #(
    parameter int unsigned MAX_MIN      = 59,
    parameter bit          INIT_RUNNING = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] s0,
    output logic [3:0] s1,
    output logic [3:0] m0,
    output logic [3:0] m1,
    output logic       running
);

`ifdef STOPWATCH_SATURATE_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    // MAX_MIN split into BCD digits once, at elaboration.
    localparam logic [3:0] MaxM1 = 4'(MAX_MIN / 10);
    localparam logic [3:0] MaxM0 = 4'(MAX_MIN % 10);

    typedef enum logic {
        StPaused = 1'b0,
        StRun    = 1'b1
    } state_e;

    localparam state_e StReset = INIT_RUNNING ? StRun : StPaused;

    state_e     state_q, state_d;
    logic [3:0] s0_q, s0_d;
    logic [3:0] s1_q, s1_d;
    logic [3:0] m0_q, m0_d;
    logic [3:0] m1_q, m1_d;

    logic       sec_at_max;
    logic       min_at_max;
    logic       run_tick;
    logic       sat_hit;
    logic [3:0] s0_inc, s1_inc, m0_inc, m1_inc;

    always_comb begin
        s0_d    = s0_q;
        s1_d    = s1_q;
        m0_d    = m0_q;
        m1_d    = m1_q;
        state_d = state_q;

        sec_at_max = (s1_q == 4'd5) && (s0_q == 4'd9);
        min_at_max = (m1_q == MaxM1) && (m0_q == MaxM0);

        // Incremented field values, shared by normal counting and adjust.
        s0_inc = (s0_q == 4'd9) ? 4'd0 : s0_q + 4'd1;
        s1_inc = (s0_q != 4'd9) ? s1_q :
                 (s1_q == 4'd5) ? 4'd0 : s1_q + 4'd1;
        m0_inc = min_at_max       ? 4'd0 :
                 (m0_q == 4'd9)   ? 4'd0 : m0_q + 4'd1;
        m1_inc = min_at_max       ? 4'd0 :
                 (m0_q == 4'd9)   ? m1_q + 4'd1 : m1_q;

        // Tick qualified by the state before any pause toggle this cycle.
        run_tick = !adj && (state_q == StRun) && tick_1hz;
        sat_hit  = SatEn && run_tick && sec_at_max && min_at_max;

        if (adj) begin
            // Adjust: only the selected field moves, seconds never carry.
            if (tick_2hz) begin
                if (sel) begin
                    s0_d = s0_inc;
                    s1_d = s1_inc;
                end else begin
                    m0_d = m0_inc;
                    m1_d = m1_inc;
                end
            end
        end else if (run_tick && !sat_hit) begin
            s0_d = s0_inc;
            s1_d = s1_inc;
            if (sec_at_max) begin
                m0_d = m0_inc;
                m1_d = m1_inc;
            end
        end

        if (pause) begin
            state_d = (state_q == StRun) ? StPaused : StRun;
        end
        if (sat_hit) begin
            state_d = StPaused;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q    <= 4'd0;
            s1_q    <= 4'd0;
            m0_q    <= 4'd0;
            m1_q    <= 4'd0;
            state_q <= StReset;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            m0_q    <= m0_d;
            m1_q    <= m1_d;
            state_q <= state_d;
        end
    end

    assign s0      = s0_q;
    assign s1      = s1_q;
    assign m0      = m0_q;
    assign m1      = m1_q;
    assign running = (state_q == StRun);

endmodule

// File: tb/tb_stopwatch_counter.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_counter
//
// Directed bench for stopwatch_counter with MAX_MIN = 59, INIT_RUNNING = 1.
// Digits are compared as a packed {m1, m0, s1, s0} word, so 12:34 = 16'h1234.
// ---------------------------------------------------------------------------
module tb_stopwatch_counter;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [3:0] s0, s1, m0, m1;
    logic       running;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_counter #(
        .MAX_MIN      (59),
        .INIT_RUNNING (1'b1)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .tick_2hz (tick_2hz),
        .pause    (pause),
        .adj      (adj),
        .sel      (sel),
        .s0       (s0),
        .s1       (s1),
        .m0       (m0),
        .m1       (m1),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] digits();
        return {m1, m0, s1, s0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of strobes, then sample 1 time unit after the edge.
    task automatic step(input bit t1, input bit t2, input bit p);
        tick_1hz = t1;
        tick_2hz = t2;
        pause    = p;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause    = 1'b0;
    endtask

    task automatic steps(input int n, input bit t1, input bit t2);
        for (int i = 0; i < n; i++) step(t1, t2, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
        pause    = 1'b0;
        adj      = 1'b0;
        sel      = 1'b0;

        // 1: reset state and 61 normal ticks
        do_reset();
        check("reset_digits", {16'd0, digits()}, 32'h0000);
        check("reset_running", {31'd0, running}, 32'd1);
        steps(61, 1'b1, 1'b0);
        check("t1_0101", {16'd0, digits()}, 32'h0101);
        check("t1_running", {31'd0, running}, 32'd1);

        // 2: preload 59:58 through adjust (also covers minutes wrap 59->00)
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        steps(59, 1'b0, 1'b1);
        check("adj_min_59", {16'd0, digits()}, 32'h5900);
        step(1'b0, 1'b1, 1'b0);
        check("adj_min_wrap", {16'd0, digits()}, 32'h0000);
        steps(59, 1'b0, 1'b1);
        sel = 1'b1;
        steps(58, 1'b0, 1'b1);
        check("preload_5958", {16'd0, digits()}, 32'h5958);
        adj = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check("t2_5959", {16'd0, digits()}, 32'h5959);
        step(1'b1, 1'b0, 1'b0);
`ifdef STOPWATCH_SATURATE_EN
        check("t2_sat_hold", {16'd0, digits()}, 32'h5959);
        check("t2_sat_running", {31'd0, running}, 32'd0);
`else
        check("t2_wrap_0000", {16'd0, digits()}, 32'h0000);
        check("t2_wrap_running", {31'd0, running}, 32'd1);
`endif

        // 3: pause holds, resume continues
        do_reset();
        steps(5, 1'b1, 1'b0);
        check("t3_0005", {16'd0, digits()}, 32'h0005);
        step(1'b0, 1'b0, 1'b1);
        steps(10, 1'b1, 1'b0);
        check("t3_paused_hold", {16'd0, digits()}, 32'h0005);
        check("t3_paused_running", {31'd0, running}, 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("t3_resumed", {31'd0, running}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("t3_0006", {16'd0, digits()}, 32'h0006);

        // 4: seconds adjust wraps without carry, then minutes adjust
        adj = 1'b1;
        sel = 1'b1;
        steps(52, 1'b0, 1'b1);
        check("t4_0058", {16'd0, digits()}, 32'h0058);
        step(1'b0, 1'b1, 1'b0);
        check("t4_0059", {16'd0, digits()}, 32'h0059);
        step(1'b1, 1'b0, 1'b0);
        check("t4_1hz_ignored", {16'd0, digits()}, 32'h0059);
        step(1'b0, 1'b1, 1'b0);
        check("t4_sec_wrap", {16'd0, digits()}, 32'h0000);
        step(1'b1, 1'b1, 1'b0);
        check("t4_both_ticks", {16'd0, digits()}, 32'h0001);
        sel = 1'b0;
        steps(2, 1'b0, 1'b1);
        check("t4_0201", {16'd0, digits()}, 32'h0201);
        step(1'b1, 1'b0, 1'b0);
        check("t4_1hz_ignored2", {16'd0, digits()}, 32'h0201);
        step(1'b0, 1'b0, 1'b1);
        check("t4_pause_in_adj", {31'd0, running}, 32'd0);
        step(1'b0, 1'b1, 1'b0);
        check("t4_adj_while_paused", {16'd0, digits()}, 32'h0301);
        step(1'b0, 1'b0, 1'b1);
        adj = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check("t4_resume_count", {16'd0, digits()}, 32'h0302);

        // 5: pause coincident with tick_1hz
        do_reset();
        steps(10, 1'b1, 1'b0);
        check("t5_0010", {16'd0, digits()}, 32'h0010);
        step(1'b1, 1'b0, 1'b1);
        check("t5_run_tick", {16'd0, digits()}, 32'h0011);
        check("t5_run_to_paused", {31'd0, running}, 32'd0);
        step(1'b1, 1'b0, 1'b1);
        check("t5_paused_hold", {16'd0, digits()}, 32'h0011);
        check("t5_paused_to_run", {31'd0, running}, 32'd1);

        // 6: reset dominates tick and pause at 12:34
        do_reset();
        adj = 1'b1;
        sel = 1'b0;
        steps(12, 1'b0, 1'b1);
        sel = 1'b1;
        steps(34, 1'b0, 1'b1);
        adj = 1'b0;
        check("t6_1234", {16'd0, digits()}, 32'h1234);
        step(1'b0, 1'b0, 1'b1);
        check("t6_paused", {31'd0, running}, 32'd0);
        rst = 1'b1;
        step(1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        check("t6_rst_digits", {16'd0, digits()}, 32'h0000);
        check("t6_rst_running", {31'd0, running}, 32'd1);
        step(1'b1, 1'b0, 1'b0);
        check("t6_after_rst", {16'd0, digits()}, 32'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
BCD minutes:seconds time base that produces the four digits (s0, s1, m0, m1) consumed by the seven-segment display stage.
- Runs in the single system clock domain. Time is advanced by one-cycle enable strobes from the clock-divider block, never by derived clocks.
- Supports pause/resume and an adjust mode that fast-increments either the minutes field or the seconds field.
- Sits directly upstream of the display decoder and shares adj/sel with it.

Parameters:
MAX_MIN, 59, highest minutes value before wrap; legal range 1..99, held internally as BCD.
INIT_RUNNING, 1, state after reset: 1 = RUN, 0 = PAUSED.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
tick_1hz  input  1  one-cycle strobe, 1 Hz, drives normal counting
tick_2hz  input  1  one-cycle strobe, 2 Hz, drives adjust increments
pause  input  1  debounced one-cycle pulse; toggles RUN/PAUSED
adj  input  1  level; 1 = adjust mode
sel  input  1  level; field to adjust: 1 = seconds, 0 = minutes
s0  output  4  seconds ones digit, BCD 0-9
s1  output  4  seconds tens digit, BCD 0-5
m0  output  4  minutes ones digit, BCD 0-9
m1  output  4  minutes tens digit, BCD 0-9, bounded by MAX_MIN
running  output  1  1 when the state is RUN

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, and has priority over all other inputs.
- Reset values: s0 = s1 = m0 = m1 = 0; running = INIT_RUNNING.
- All outputs are registered. A digit changes on the clk edge at which the qualifying strobe is sampled high, so latency is 1 cycle.
- State machine has two states, RUN and PAUSED. A pause pulse toggles the state on the next edge. The pause pulse is honoured in both normal mode and adjust mode.
- Normal counting (adj = 0, state RUN, tick_1hz = 1):
  - Increment s0.
  - s0 wraps 9→0 and carries into s1.
  - s1 wraps 5→0 and carries into the minutes field.
  - Minutes increment in BCD (m0 9→0 carries into m1).
  - At minutes = MAX_MIN with a carry in, minutes wrap to 00.
  - With MAX_MIN = 59, 59:59 → 00:00.
- Paused (adj = 0, state PAUSED): digits hold; tick_1hz is ignored.
- Adjust mode (adj = 1):
  - tick_1hz is ignored regardless of state.
  - On tick_2hz, only the field chosen by sel is incremented.
  - Seconds wrap 59→00 with no carry into minutes.
  - Minutes wrap MAX_MIN→00.
  - The unselected field holds.
  - Adjust increments occur in both RUN and PAUSED.
- Mode changes:
  - Leaving adjust (adj 1→0) resumes in the current state. The next tick_1hz counts normally from the adjusted value.
  - Changing sel mid-adjust takes effect on the next tick_2hz; there is no partial update.
- Simultaneous events:
  - pause together with tick_1hz: the tick is qualified by the state before the toggle. In RUN the count advances and the state goes to PAUSED; in PAUSED the count holds and the state goes to RUN.
  - tick_1hz and tick_2hz in the same cycle with adj = 1: only the adjust increment applies.
- Digits are always valid BCD. No output ever shows A-F, so the display's blank default is never triggered by this block.
- Reset asserted mid-count or mid-adjust clears all digits on that edge, with no residual carry.

Optional Feature:
STOPWATCH_SATURATE_EN
- Defined: in normal counting, a tick at MAX_MIN:59 holds the digits at MAX_MIN:59 and forces the state to PAUSED (running = 0) on the same edge. A subsequent pause pulse resumes into RUN, but the digits stay saturated until reset or an adjust increment. Adjust-mode wrapping is unchanged.
- Undefined: wrap to 00:00 and keep running, as described in Behaviour.

Test Plan:
1. Reset, INIT_RUNNING = 1, apply 61 tick_1hz strobes → digits 01:01 (m1 = 0, m0 = 1, s1 = 0, s0 = 1); running = 1.
2. Preload to 59:58 via adjust, adj = 0, apply 2 tick_1hz → 59:59 then 00:00. With STOPWATCH_SATURATE_EN defined: held at 59:59 and running = 0.
3. Running at 00:05: pause pulse, then 10 tick_1hz → stays 00:05, running = 0. Second pause pulse, then 1 tick_1hz → 00:06.
4. adj = 1, sel = 1, at 00:58 with 3 tick_2hz → 00:59, 00:00, 00:01, minutes stay 00. Then sel = 0 with 2 tick_2hz → 02:01. tick_1hz strobes in between change nothing.
5. Same-cycle pause + tick_1hz in RUN at 00:10 → 00:11 and running = 0. Same-cycle in PAUSED → 00:11 held and running = 1.
6. rst asserted in the same cycle as tick_1hz and pause while at 12:34 → 00:00, running = INIT_RUNNING on that edge.
